// File: rtl/clint_timer.sv
// clint_timer: core-local interruptor with memory-mapped msip, mtimecmp and a
// free-running mtime. It has a one-outstanding request/response port with a
// registered response, so a read completes one cycle after it is accepted.
module clint_timer #(
    parameter logic [63:0] BASE_ADDR = 64'h0200_0000,
    parameter int unsigned TICK_DIV  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [7:0]  req_wstrb,
    output logic        addr_hit,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic        clint_mtip,
    output logic        clint_msip
);

    // Prescaler width; TICK_DIV=1 still needs a 1-bit counter that sits at 0.
    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PCNT_LAST = PW'(TICK_DIV - 1);

    localparam logic [15:0] OFF_MSIP     = 16'h0000;
    localparam logic [15:0] OFF_MTIMECMP = 16'h4000;
    localparam logic [15:0] OFF_MTIME    = 16'hBFF8;

    logic [63:0]   mtime_reg;
    logic [63:0]   mtimecmp_reg;
    logic          msip_reg;
    logic [PW-1:0] pcnt_reg;

    logic          resp_valid_reg;
    logic [63:0]   resp_rdata_reg;
    logic          resp_err_reg;

    logic [15:0]   offset;
    logic          aligned;
    logic          sel_msip;
    logic          sel_mtimecmp;
    logic          sel_mtime;
    logic          sel_any;
    logic          accept;
    logic          tick;
    logic          wr_msip;
    logic          wr_mtimecmp;
    logic          wr_mtime;
    logic [63:0]   wmask;
    logic [63:0]   mtime_merged;
    logic [63:0]   mtimecmp_merged;
    logic          msip_merged;
    logic [63:0]   read_data;

    // The window is 64 KiB aligned, so a hit is just a match of the upper bits.
    assign addr_hit = (req_addr[63:16] == BASE_ADDR[63:16]);
    assign offset   = req_addr[15:0];
    assign aligned  = (req_addr[2:0] == 3'b000);

    assign sel_msip     = addr_hit & aligned & (offset == OFF_MSIP);
    assign sel_mtimecmp = addr_hit & aligned & (offset == OFF_MTIMECMP);
    assign sel_mtime    = addr_hit & aligned & (offset == OFF_MTIME);
    assign sel_any      = sel_msip | sel_mtimecmp | sel_mtime;

    // Only one request may be outstanding: block while a response waits.
    assign req_ready = ~resp_valid_reg;
    assign accept    = req_valid & ~resp_valid_reg;

    assign wr_msip     = accept & req_wen & sel_msip;
    assign wr_mtimecmp = accept & req_wen & sel_mtimecmp;
    assign wr_mtime    = accept & req_wen & sel_mtime;

    assign tick = (pcnt_reg == PCNT_LAST);

    // Expand the byte strobes into a bit mask for the read-modify-write merge.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_wmask
            assign wmask[8*gi +: 8] = {8{req_wstrb[gi]}};
        end
    endgenerate

    assign mtime_merged    = (mtime_reg & ~wmask) | (req_wdata & wmask);
    assign mtimecmp_merged = (mtimecmp_reg & ~wmask) | (req_wdata & wmask);
    assign msip_merged     = req_wstrb[0] ? req_wdata[0] : msip_reg;

    // Read mux: values are those held during the accept cycle.
    always_comb begin
        read_data = 64'd0;
        if (sel_msip) begin
            read_data = {63'd0, msip_reg};
        end else if (sel_mtimecmp) begin
            read_data = mtimecmp_reg;
        end else if (sel_mtime) begin
            read_data = mtime_reg;
        end
    end

    // Timebase: a write to mtime overrides the tick and restarts the prescaler.
    always_ff @(posedge clk) begin
        if (rst) begin
            mtime_reg <= 64'd0;
            pcnt_reg  <= '0;
        end else if (wr_mtime) begin
            mtime_reg <= mtime_merged;
            pcnt_reg  <= '0;
        end else if (tick) begin
            mtime_reg <= mtime_reg + 64'd1;
            pcnt_reg  <= '0;
        end else begin
            pcnt_reg  <= pcnt_reg + 1'b1;
        end
    end

    // Software-visible compare and software interrupt registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            mtimecmp_reg <= 64'hFFFF_FFFF_FFFF_FFFF;
            msip_reg     <= 1'b0;
        end else begin
            if (wr_mtimecmp) begin
                mtimecmp_reg <= mtimecmp_merged;
            end
            if (wr_msip) begin
                msip_reg <= msip_merged;
            end
        end
    end

    // Registered response: captured at accept, held until the handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid_reg <= 1'b0;
            resp_rdata_reg <= 64'd0;
            resp_err_reg   <= 1'b0;
        end else if (accept) begin
            resp_valid_reg <= 1'b1;
            resp_rdata_reg <= (~req_wen & sel_any) ? read_data : 64'd0;
            resp_err_reg   <= ~sel_any;
        end else if (resp_valid_reg & resp_ready) begin
            resp_valid_reg <= 1'b0;
            resp_rdata_reg <= 64'd0;
            resp_err_reg   <= 1'b0;
        end
    end

    assign resp_valid = resp_valid_reg;
    assign resp_rdata = resp_rdata_reg;
    assign resp_err   = resp_err_reg;

    assign clint_mtip = (mtime_reg >= mtimecmp_reg);
    assign clint_msip = msip_reg;

endmodule

// File: tb/tb_clint_timer.sv
// tb_clint_timer: randomized and directed stimulus against an arithmetic model
// of the timer (mtime as a function of elapsed cycles), with a queue-based
// scoreboard for responses and per-cycle checks of the interrupt outputs.
module tb_clint_timer;

    localparam logic [63:0] BASE = 64'h0200_0000;
    localparam int unsigned TD   = 4;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_wen = 1'b0;
    logic [63:0] req_addr = 64'd0;
    logic [63:0] req_wdata = 64'd0;
    logic [7:0]  req_wstrb = 8'd0;
    logic        addr_hit;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic        clint_mtip;
    logic        clint_msip;

    clint_timer #(.BASE_ADDR(BASE), .TICK_DIV(TD)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wen    (req_wen),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_wstrb  (req_wstrb),
        .addr_hit   (addr_hit),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .clint_mtip (clint_mtip),
        .clint_msip (clint_msip)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] rdata;
        logic        err;
        int unsigned acc;
        logic        wen;
        logic [63:0] addr;
    } exp_t;

    exp_t        expq[$];
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          txn = 0;
    logic        rr_low = 1'b0;
    logic        prev_rv = 1'b0;

    // Reference state: mtime(n) = mt_base + (n - mt_cbase) / TD.
    logic [63:0] mt_base = 64'd0;
    int unsigned mt_cbase = 0;
    logic [63:0] cmp_m = ONES;
    logic        msip_m = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] mt_now(int unsigned n);
        return mt_base + 64'((n - mt_cbase) / TD);
    endfunction

    function automatic logic [63:0] merge(logic [63:0] old, logic [63:0] wd, logic [7:0] st);
        logic [63:0] r;
        r = old;
        for (int i = 0; i < 8; i++) begin
            if (st[i]) r[8*i +: 8] = wd[8*i +: 8];
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // resp_ready: random back-pressure unless forced low; driven at #2 so
    // rr_low changes made at #1 take effect in the same cycle.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            resp_ready = rr_low ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: interrupt lines every cycle, responses against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_rv = 1'b0;
            end else begin
                chk("req_ready", {63'd0, req_ready}, {63'd0, ~resp_valid});
                chk("mtip", {63'd0, clint_mtip}, {63'd0, (mt_now(cyc) >= cmp_m)});
                chk("msip", {63'd0, clint_msip}, {63'd0, msip_m});
                if (resp_valid) begin
                    if (expq.size() == 0) begin
                        chk("unexpected_resp", 64'd1, 64'd0);
                    end else begin
                        if (!prev_rv) chk("latency", 64'(cyc), 64'(expq[0].acc + 1));
                        chk("rdata", resp_rdata, expq[0].rdata);
                        chk("err", {63'd0, resp_err}, {63'd0, expq[0].err});
                        if (resp_ready) begin
                            $display("txn %0d: %s addr=%h rdata=%h err=%0d", txn,
                                     expq[0].wen ? "WR" : "RD", expq[0].addr, resp_rdata, resp_err);
                            txn++;
                            void'(expq.pop_front());
                        end
                    end
                end
                prev_rv = resp_valid;
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        mt_base = 64'd0;
        mt_cbase = cyc;
        cmp_m = ONES;
        msip_m = 1'b0;
        expq.delete();
    endtask

    // Issue one request (called just after a posedge); returns after acceptance.
    task automatic do_req(input logic wen, input logic [63:0] addr,
                          input logic [63:0] wdata, input logic [7:0] wstrb);
        logic        hit, valid, accepted;
        logic [63:0] off, old, nv;
        exp_t        e;
        int          n;
        req_valid = 1'b1;
        req_wen = wen;
        req_addr = addr;
        req_wdata = wdata;
        req_wstrb = wstrb;
        hit = (addr >= BASE) && ((addr - BASE) < 64'h1_0000);
        off = addr - BASE;
        valid = hit && (addr[2:0] == 3'd0) &&
                (off == 64'h0 || off == 64'h4000 || off == 64'hBFF8);
        accepted = 1'b0;
        n = 0;
        while (!accepted && n < 300) begin
            @(negedge clk);
            if (n == 0) chk("addr_hit", {63'd0, addr_hit}, {63'd0, hit});
            if (req_ready) accepted = 1'b1;
            n++;
        end
        if (!accepted) begin
            chk("accept_timeout", 64'd0, 64'd1);
            @(posedge clk);
            #1;
            req_valid = 1'b0;
            return;
        end
        old = 64'd0;
        if (valid && off == 64'h0) old = {63'd0, msip_m};
        if (valid && off == 64'h4000) old = cmp_m;
        if (valid && off == 64'hBFF8) old = mt_now(cyc);
        e.rdata = (!wen && valid) ? old : 64'd0;
        e.err = !valid;
        e.acc = cyc;
        e.wen = wen;
        e.addr = addr;
        expq.push_back(e);
        nv = merge(old, wdata, wstrb);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        if (wen && valid) begin
            if (off == 64'h0) msip_m = nv[0];
            if (off == 64'h4000) cmp_m = nv;
            if (off == 64'hBFF8) begin
                mt_base = nv;
                mt_cbase = cyc;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (expq.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (expq.size() != 0) chk("drain_timeout", 64'(expq.size()), 64'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned c0;
        logic [63:0] a, d;
        logic [7:0]  s;
        int          k;

        do_reset();
        @(negedge clk);
        chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
        chk("rst_rdata", resp_rdata, 64'd0);
        chk("rst_err", {63'd0, resp_err}, 64'd0);
        chk("rst_mtip", {63'd0, clint_mtip}, 64'd0);
        chk("rst_msip", {63'd0, clint_msip}, 64'd0);
        @(posedge clk);
        #1;

        // Read mtime after 40 cycles of counting: expects 40/TD = 10.
        c0 = mt_cbase;
        while (cyc < c0 + 40) begin
            @(posedge clk);
            #1;
        end
        do_req(1'b0, BASE + 64'hBFF8, 64'd0, 8'h00);
        drain();

        // Compare slightly ahead of mtime, watch mtip rise, then disarm.
        do_req(1'b1, BASE + 64'h4000, mt_now(cyc) + 64'd5, 8'hFF);
        drain();
        idle(40);
        do_req(1'b1, BASE + 64'h4000, ONES, 8'hFF);
        drain();
        idle(3);

        // msip write of 3 stores bit0 only; partial mtimecmp byte write.
        do_req(1'b1, BASE, 64'h3, 8'hFF);
        do_req(1'b0, BASE, 64'd0, 8'h00);
        do_req(1'b1, BASE + 64'h4000, 64'hAB, 8'h01);
        do_req(1'b0, BASE + 64'h4000, 64'd0, 8'h00);

        // Error paths: reserved offset, misaligned, outside window, bad write.
        do_req(1'b0, BASE + 64'h8, 64'd0, 8'h00);
        do_req(1'b0, BASE + 64'hBFF9, 64'd0, 8'h00);
        do_req(1'b0, BASE + 64'h1_0000, 64'd0, 8'h00);
        do_req(1'b1, BASE + 64'h4004, 64'h0, 8'hFF);
        do_req(1'b1, BASE + 64'hBFF9, 64'h0, 8'hFF);
        do_req(1'b0, BASE + 64'h4000, 64'd0, 8'h00);
        // Zero-strobe write completes without error or change.
        do_req(1'b1, BASE + 64'hBFF8, 64'h1234, 8'h00);
        do_req(1'b0, BASE + 64'hBFF8, 64'd0, 8'h00);
        drain();

        // Back-pressure: response held 5 cycles, second request must wait.
        rr_low = 1'b1;
        do_req(1'b0, BASE, 64'd0, 8'h00);
        fork
            begin
                repeat (5) @(posedge clk);
                #1;
                rr_low = 1'b0;
            end
            do_req(1'b0, BASE + 64'h4000, 64'd0, 8'h00);
        join
        drain();

        // mtime write landing in a tick cycle, then wrap from all-ones.
        while (((cyc - mt_cbase) % TD) != TD - 1) begin
            @(posedge clk);
            #1;
        end
        do_req(1'b1, BASE + 64'hBFF8, 64'd100, 8'hFF);
        do_req(1'b0, BASE + 64'hBFF8, 64'd0, 8'h00);
        drain();
        idle(7);
        do_req(1'b0, BASE + 64'hBFF8, 64'd0, 8'h00);
        do_req(1'b1, BASE + 64'hBFF8, ONES, 8'hFF);
        drain();
        idle(TD + 1);
        do_req(1'b0, BASE + 64'hBFF8, 64'd0, 8'h00);
        drain();

        // Randomized traffic.
        for (int i = 0; i < 150; i++) begin
            k = $urandom_range(0, 9);
            s = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'hFF;
            d = {32'($urandom), 32'($urandom)};
            case (k)
                0, 1: a = BASE + 64'hBFF8;
                2, 3: a = BASE + 64'h4000;
                4:    a = BASE;
                5:    a = BASE + 64'($urandom_range(0, 16'hFFFF));
                6:    a = BASE + 64'h4000 + 64'($urandom_range(1, 7));
                7:    a = {32'($urandom), 32'($urandom)};
                default: a = BASE + 64'h4000;
            endcase
            if (k == 8 || k == 9) d = mt_now(cyc) + 64'($urandom_range(0, 12));
            do_req(($urandom_range(0, 1) == 1), a, d, s);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 6));
        end
        drain();

        // Reset while a response is pending drops it.
        rr_low = 1'b1;
        do_req(1'b0, BASE + 64'hBFF8, 64'd0, 8'h00);
        idle(2);
        do_reset();
        rr_low = 1'b0;
        @(negedge clk);
        chk("rst_drop_resp_valid", {63'd0, resp_valid}, 64'd0);
        chk("rst_drop_req_ready", {63'd0, req_ready}, 64'd1);
        @(posedge clk);
        #1;
        do_req(1'b0, BASE + 64'hBFF8, 64'd0, 8'h00);
        drain();
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
